// File: rtl/pulp_clock_gate_ctrl.sv
// Clock-gate enable sequencer: per-domain OFF/WAKE/ON/LINGER handshake with
// idle hysteresis, plus a round-robin wake arbiter that staggers switch-on so
// no two gating cells open within STAGGER_CYC cycles of each other.
module pulp_clock_gate_ctrl #(
    parameter int N_DOMAINS   = 4,
    parameter int STABLE_CYC  = 2,
    parameter int IDLE_CYC    = 8,
    parameter int STAGGER_CYC = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_DOMAINS-1:0] clk_req_i,
    input  logic                 force_on_i,
    output logic [N_DOMAINS-1:0] clk_en_o,
    output logic [N_DOMAINS-1:0] clk_ack_o,
    output logic                 wake_busy_o
);

    localparam int CNT_MAX = (STABLE_CYC > IDLE_CYC) ? STABLE_CYC : IDLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
    localparam int STG_W   = $clog2(STAGGER_CYC + 1);

    localparam logic [CNT_W-1:0] STABLE_LD = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] IDLE_LD   = CNT_W'(IDLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [STG_W-1:0] STG_LD    = STG_W'(STAGGER_CYC - 1);
    localparam logic [STG_W-1:0] STG_ONE   = STG_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_DOMAINS - 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   N_EXT     = (PTR_W + 1)'(N_DOMAINS);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WAKE   = 2'd1,
        ST_ON     = 2'd2,
        ST_LINGER = 2'd3
    } state_t;

    state_t             state_q [N_DOMAINS];
    state_t             state_d [N_DOMAINS];
    logic [CNT_W-1:0]   cnt_q   [N_DOMAINS];
    logic [CNT_W-1:0]   cnt_d   [N_DOMAINS];

    logic [N_DOMAINS-1:0] cand;
    logic [N_DOMAINS-1:0] grant;
    logic                 grant_any;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     ptr_d;
    logic [STG_W-1:0]     stagger_q;
    logic [STG_W-1:0]     stagger_d;

    logic [N_DOMAINS-1:0] en_d;
    logic [N_DOMAINS-1:0] ack_d;
    logic                 busy_d;

    // Wake candidates: domains that are off and asking for their clock.
    always_comb begin
        cand = '0;
        for (int d = 0; d < N_DOMAINS; d++) begin
            cand[d] = (state_q[d] == ST_OFF) && clk_req_i[d];
        end
    end

    // Round-robin pick of one candidate starting at ptr, only once the stagger gap has elapsed.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        if (stagger_q == '0) begin
            for (int i = 0; i < N_DOMAINS; i++) begin
                sum = {1'b0, ptr_q} + (PTR_W + 1)'(i);
                if (sum >= N_EXT) begin
                    sum = sum - N_EXT;
                end
                idx = sum[PTR_W-1:0];
                if (!grant_any && cand[idx]) begin
                    grant_any  = 1'b1;
                    grant_idx  = idx;
                    grant[idx] = 1'b1;
                end
            end
        end
    end

    // Next pointer and stagger gap after this edge's grant decision.
    always_comb begin
        ptr_d     = ptr_q;
        stagger_d = stagger_q;
        if (grant_any) begin
            ptr_d     = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_ONE;
            stagger_d = STG_LD;
        end else if (stagger_q != '0) begin
            stagger_d = stagger_q - STG_ONE;
        end
    end

    // Per-domain next state and counter; a live request always wins over linger expiry.
    always_comb begin
        for (int d = 0; d < N_DOMAINS; d++) begin
            state_d[d] = state_q[d];
            cnt_d[d]   = cnt_q[d];
            case (state_q[d])
                ST_OFF: begin
                    if (grant[d]) begin
                        state_d[d] = ST_WAKE;
                        cnt_d[d]   = STABLE_LD;
                    end
                end
                ST_WAKE: begin
                    if (cnt_q[d] <= CNT_ONE) begin
                        if (clk_req_i[d]) begin
                            state_d[d] = ST_ON;
                            cnt_d[d]   = '0;
                        end else if (IDLE_CYC == 0) begin
                            state_d[d] = ST_OFF;
                            cnt_d[d]   = '0;
                        end else begin
                            state_d[d] = ST_LINGER;
                            cnt_d[d]   = IDLE_LD;
                        end
                    end else begin
                        cnt_d[d] = cnt_q[d] - CNT_ONE;
                    end
                end
                ST_ON: begin
                    if (!clk_req_i[d]) begin
                        if (IDLE_CYC == 0) begin
                            state_d[d] = ST_OFF;
                            cnt_d[d]   = '0;
                        end else begin
                            state_d[d] = ST_LINGER;
                            cnt_d[d]   = IDLE_LD;
                        end
                    end
                end
                ST_LINGER: begin
                    if (clk_req_i[d]) begin
                        state_d[d] = ST_ON;
                        cnt_d[d]   = '0;
                    end else if (cnt_q[d] <= CNT_ONE) begin
                        state_d[d] = ST_OFF;
                        cnt_d[d]   = '0;
                    end else begin
                        cnt_d[d] = cnt_q[d] - CNT_ONE;
                    end
                end
                default: begin
                    state_d[d] = ST_OFF;
                    cnt_d[d]   = '0;
                end
            endcase
        end
    end

    // Output values derived from the next state so enable/ack change on the deciding edge.
    always_comb begin
        en_d   = '0;
        ack_d  = '0;
        busy_d = 1'b0;
        for (int d = 0; d < N_DOMAINS; d++) begin
            en_d[d]  = (state_d[d] != ST_OFF) || force_on_i;
            ack_d[d] = (state_d[d] == ST_ON) || (state_d[d] == ST_LINGER);
            if ((state_d[d] == ST_WAKE) || (cand[d] && !grant[d])) begin
                busy_d = 1'b1;
            end
        end
    end

    // Per-domain state and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int d = 0; d < N_DOMAINS; d++) begin
                state_q[d] <= ST_OFF;
                cnt_q[d]   <= '0;
            end
        end else begin
            for (int d = 0; d < N_DOMAINS; d++) begin
                state_q[d] <= state_d[d];
                cnt_q[d]   <= cnt_d[d];
            end
        end
    end

    // Arbiter pointer and stagger gap registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            stagger_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            stagger_q <= stagger_d;
        end
    end

    // Registered outputs to the gating cells and requesters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_en_o    <= '0;
            clk_ack_o   <= '0;
            wake_busy_o <= 1'b0;
        end else begin
            clk_en_o    <= en_d;
            clk_ack_o   <= ack_d;
            wake_busy_o <= busy_d;
        end
    end

endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// Directed bench for pulp_clock_gate_ctrl with default parameters
// (4 domains, STABLE_CYC=2, IDLE_CYC=8, STAGGER_CYC=4).
// Edge numbering: "edge 0" is the first rising edge after reset is released.
module tb_pulp_clock_gate_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       force_on;
    logic [3:0] en;
    logic [3:0] ack;
    logic       busy;

    int checks = 0;
    int errors = 0;

    pulp_clock_gate_ctrl #(
        .N_DOMAINS  (4),
        .STABLE_CYC (2),
        .IDLE_CYC   (8),
        .STAGGER_CYC(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clk_req_i  (req),
        .force_on_i (force_on),
        .clk_en_o   (en),
        .clk_ack_o  (ack),
        .wake_busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = 4'b0000;
        force_on = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_en;
        logic [3:0] exp_ack;

        rst      = 1'b1;
        req      = 4'b0000;
        force_on = 1'b0;

        // Reset state
        do_reset();
        chk("rst_en", 32'(en), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Single domain wake, then linger and switch-off
        req = 4'b0001;
        tick(); // edge 0
        chk("t1_en_e0", 32'(en), 32'h1);
        chk("t1_ack_e0", 32'(ack), 32'h0);
        chk("t1_busy_e0", 32'(busy), 32'h1);
        tick(); // edge 1
        chk("t1_ack_e1", 32'(ack), 32'h0);
        tick(); // edge 2
        chk("t1_ack_e2", 32'(ack), 32'h1);
        chk("t1_en_e2", 32'(en), 32'h1);
        chk("t1_busy_e2", 32'(busy), 32'h0);
        for (int k = 3; k <= 9; k++) tick();
        req = 4'b0000;
        for (int k = 10; k <= 17; k++) begin
            tick();
            chk("t2_en_linger", 32'(en), 32'h1);
            chk("t2_ack_linger", 32'(ack), 32'h1);
        end
        tick(); // edge 18
        chk("t2_en_off", 32'(en), 32'h0);
        chk("t2_ack_off", 32'(ack), 32'h0);

        // Re-raise during linger: no gap, back to ON (no expiry at edge 18)
        do_reset();
        req = 4'b0001;
        for (int k = 0; k <= 9; k++) tick();
        req = 4'b0000;
        for (int k = 10; k <= 13; k++) begin
            tick();
            chk("t3_en_lo", 32'(en), 32'h1);
            chk("t3_ack_lo", 32'(ack), 32'h1);
        end
        req = 4'b0001;
        for (int k = 14; k <= 25; k++) begin
            tick();
            chk("t3_en_hi", 32'(en), 32'h1);
            chk("t3_ack_hi", 32'(ack), 32'h1);
        end

        // All four request together: staggered round-robin grants
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp_en  = 4'b0000;
            exp_ack = 4'b0000;
            for (int d = 0; d < 4; d++) begin
                if (k >= 4 * d)     exp_en[d]  = 1'b1;
                if (k >= 4 * d + 2) exp_ack[d] = 1'b1;
            end
            chk("t4_en", 32'(en), 32'(exp_en));
            chk("t4_ack", 32'(ack), 32'(exp_ack));
            chk("t4_busy", 32'(busy), (k < 14) ? 32'h1 : 32'h0);
        end

        // Force-on opens all gates without touching acks
        do_reset();
        force_on = 1'b1;
        tick();
        chk("t5_en_force", 32'(en), 32'hF);
        chk("t5_ack_force", 32'(ack), 32'h0);
        chk("t5_busy_force", 32'(busy), 32'h0);
        tick();
        chk("t5_en_force2", 32'(en), 32'hF);
        force_on = 1'b0;
        tick();
        chk("t5_en_release", 32'(en), 32'h0);

        // Request dropped during WAKE: completes wake, then lingers
        do_reset();
        req = 4'b0001;
        tick(); // edge 0
        req = 4'b0000;
        tick(); // edge 1
        tick(); // edge 2
        chk("t7_ack_e2", 32'(ack), 32'h1);
        chk("t7_en_e2", 32'(en), 32'h1);
        for (int k = 3; k <= 9; k++) tick();
        chk("t7_en_e9", 32'(en), 32'h1);
        tick(); // edge 10
        chk("t7_en_e10", 32'(en), 32'h0);
        chk("t7_ack_e10", 32'(ack), 32'h0);

        // Request withdrawn while waiting for a grant consumes nothing
        do_reset();
        req = 4'b0011;
        tick(); // edge 0
        chk("t8_en_e0", 32'(en), 32'h1);
        req = 4'b0001;
        tick(); // edge 1
        chk("t8_busy_e1", 32'(busy), 32'h1);
        tick(); // edge 2
        chk("t8_busy_e2", 32'(busy), 32'h0);
        tick();
        tick(); // edge 4
        chk("t8_en_e4", 32'(en), 32'h1);
        req = 4'b0011;
        tick(); // edge 5
        chk("t8_en_e5", 32'(en), 32'h3);

        // Reset mid-operation; pointer restarts at 0
        do_reset();
        req = 4'b0110;
        for (int k = 0; k <= 4; k++) tick();
        chk("t6_en_pre", 32'(en), 32'h6);
        chk("t6_ack_pre", 32'(ack), 32'h2);
        rst = 1'b1;
        tick(); // edge 5
        chk("t6_en_rst", 32'(en), 32'h0);
        chk("t6_ack_rst", 32'(ack), 32'h0);
        chk("t6_busy_rst", 32'(busy), 32'h0);
        rst = 1'b0;
        req = 4'b1010;
        tick(); // edge 6
        chk("t6_en_regrant", 32'(en), 32'h2);
        tick();
        tick(); // edge 8
        chk("t6_ack_regrant", 32'(ack), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
